// File: rtl/target_generator_if.sv
// rtl/target_generator_if.sv - head/target handshake bundle for target_generator
interface target_generator_if;
  logic       GAME_ACTIVE;
  logic       HEAD_VALID;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic [7:0] TARGET_X;
  logic [6:0] TARGET_Y;
  logic       TARGET_VALID;
  logic       REACHED_TARGET;

  modport master (
    output GAME_ACTIVE, HEAD_VALID, HEAD_X, HEAD_Y,
    input  TARGET_X, TARGET_Y, TARGET_VALID, REACHED_TARGET
  );

  modport slave (
    input  GAME_ACTIVE, HEAD_VALID, HEAD_X, HEAD_Y,
    output TARGET_X, TARGET_Y, TARGET_VALID, REACHED_TARGET
  );
endinterface

// File: rtl/target_generator.sv
// rtl/target_generator.sv - snake target placement: hit detection and LFSR-driven re-placement
module target_generator #(
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 60
) (
  input logic              CLK,
  input logic              RESET,
  target_generator_if.slave tgt
);

  localparam logic [7:0] X_MAX_C  = X_MAX[7:0];
  localparam logic [6:0] Y_MAX_C  = Y_MAX[6:0];
  localparam logic [7:0] X_INIT_C = X_INIT[7:0];
  localparam logic [6:0] Y_INIT_C = Y_INIT[6:0];

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    HIT      = 2'd1,
    GENERATE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       hit_cnt_q, hit_cnt_d;
  logic [7:0] target_x_q, target_x_d;
  logic [6:0] target_y_q, target_y_d;
  logic [7:0] head_x_q, head_x_d;
  logic [6:0] head_y_q, head_y_d;
  logic [7:0] lfsr_x_q, lfsr_x_d;
  logic [6:0] lfsr_y_q, lfsr_y_d;

  logic head_match;
  logic cand_ok;

  // Maximal-length taps: from a non-zero seed neither register reaches all-zeros.
  always_comb begin
    lfsr_x_d = {lfsr_x_q[6:0], lfsr_x_q[7] ^ lfsr_x_q[5] ^ lfsr_x_q[4] ^ lfsr_x_q[3]};
    lfsr_y_d = {lfsr_y_q[5:0], lfsr_y_q[6] ^ lfsr_y_q[5]};
  end

  always_comb begin
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    if (tgt.HEAD_VALID) begin
      head_x_d = tgt.HEAD_X;
      head_y_d = tgt.HEAD_Y;
    end
  end

  assign head_match = tgt.GAME_ACTIVE && tgt.HEAD_VALID &&
                      (tgt.HEAD_X == target_x_q) && (tgt.HEAD_Y == target_y_q);

  // Candidate is checked against the head registered before this cycle.
  assign cand_ok = (lfsr_x_q <= X_MAX_C) && (lfsr_y_q <= Y_MAX_C) &&
                   !((lfsr_x_q == head_x_q) && (lfsr_y_q == head_y_q));

  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = 1'b0;
    target_x_d = target_x_q;
    target_y_d = target_y_q;
    case (state_q)
      ARMED: begin
        if (head_match) begin
          state_d = HIT;
        end
      end
      HIT: begin
        hit_cnt_d = 1'b1;
        if (hit_cnt_q) begin
          hit_cnt_d = 1'b0;
          state_d   = GENERATE;
        end
      end
      GENERATE: begin
        if (cand_ok) begin
          target_x_d = lfsr_x_q;
          target_y_d = lfsr_y_q;
          state_d    = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ARMED;
      hit_cnt_q  <= 1'b0;
      target_x_q <= X_INIT_C;
      target_y_q <= Y_INIT_C;
      head_x_q   <= 8'd0;
      head_y_q   <= 7'd0;
      lfsr_x_q   <= 8'hB3;
      lfsr_y_q   <= 7'h2C;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      target_x_q <= target_x_d;
      target_y_q <= target_y_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      lfsr_x_q   <= lfsr_x_d;
      lfsr_y_q   <= lfsr_y_d;
    end
  end

  assign tgt.TARGET_X       = target_x_q;
  assign tgt.TARGET_Y       = target_y_q;
  assign tgt.TARGET_VALID   = (state_q == ARMED);
  assign tgt.REACHED_TARGET = (state_q == HIT);

endmodule

// File: doc/target_generator.md
TARGET_GENERATOR -- requirements
Module: target_generator

Interface
REQ-001 Parameter X_MAX, default 159: largest legal target X coordinate (column).
REQ-002 Parameter Y_MAX, default 119: largest legal target Y coordinate (row).
REQ-003 Parameter X_INIT, default 80: target X after reset.
REQ-004 Parameter Y_INIT, default 60: target Y after reset.
REQ-005 Port CLK  input  1: single clock; all state is updated on its rising edge.
REQ-006 Port RESET  input  1: reset, synchronous and active-high.
REQ-007 Port GAME_ACTIVE  input  1: high while the game is running; while low, hits are not detected.
REQ-008 Port HEAD_VALID  input  1: one-cycle strobe marking a new snake head position on HEAD_X/HEAD_Y.
REQ-009 Port HEAD_X  input  8: snake head column.
REQ-010 Port HEAD_Y  input  7: snake head row.
REQ-011 Port TARGET_X  output  8: current target column (registered).
REQ-012 Port TARGET_Y  output  7: current target row (registered).
REQ-013 Port TARGET_VALID  output  1: high while TARGET_X/TARGET_Y hold a placed target.
REQ-014 Port REACHED_TARGET  output  1: high for exactly 2 consecutive cycles per hit; feeds the score counter.

Function
REQ-015 Two free-running LFSRs SHALL advance every cycle, regardless of state and GAME_ACTIVE.
REQ-016 LFSR_X, 8 bits, SHALL shift left with new bit0 = b7^b5^b4^b3; reset seed 8'hB3.
REQ-017 LFSR_Y, 7 bits, SHALL shift left with new bit0 = b6^b5; reset seed 7'h2C.
REQ-018 Neither LFSR SHALL ever hold all-zeros.
REQ-019 The FSM SHALL have exactly three states: ARMED, HIT and GENERATE.
REQ-020 In ARMED, TARGET_VALID SHALL be 1 and REACHED_TARGET SHALL be 0.
REQ-021 ARMED->HIT SHALL occur when GAME_ACTIVE=1, HEAD_VALID=1, HEAD_X==TARGET_X and HEAD_Y==TARGET_Y, all in the same cycle.
REQ-022 With HEAD_VALID=0 or GAME_ACTIVE=0, a coordinate match SHALL NOT cause a transition.
REQ-023 HIT SHALL last exactly 2 cycles; REACHED_TARGET SHALL be 1 in both cycles and TARGET_VALID SHALL be 0; HIT->GENERATE then follows.
REQ-024 REACHED_TARGET SHALL rise on the clock edge that registers the matching HEAD_VALID (1-cycle latency).
REQ-025 In GENERATE, REACHED_TARGET=0 and TARGET_VALID=0.
REQ-026 In GENERATE, each cycle the current LFSR_X/LFSR_Y values SHALL form a candidate.
REQ-027 A candidate SHALL be accepted only if LFSR_X<=X_MAX, LFSR_Y<=Y_MAX, and (LFSR_X,LFSR_Y) differs from the last HEAD_X/HEAD_Y captured on HEAD_VALID.
REQ-028 On acceptance, TARGET_X/TARGET_Y SHALL load the candidate and the FSM SHALL enter ARMED on the same edge.
REQ-029 On rejection, the FSM SHALL stay in GENERATE and retry with the next LFSR values; there is no retry limit.
REQ-030 HEAD_VALID SHALL be ignored for hit detection in HIT and GENERATE, but SHALL still update the captured head position.
REQ-031 TARGET_X/TARGET_Y SHALL hold their old value through HIT and GENERATE until a new candidate is accepted.
REQ-032 A second match arriving at the edge that leaves HIT SHALL NOT extend or retrigger REACHED_TARGET.
REQ-033 If GAME_ACTIVE falls during HIT or GENERATE, the sequence SHALL complete normally.

Reset
REQ-034 While RESET=1 at a clock edge, the block SHALL load: state ARMED, TARGET_X=X_INIT, TARGET_Y=Y_INIT, TARGET_VALID=1, REACHED_TARGET=0, LFSR_X=8'hB3, LFSR_Y=7'h2C, captured head=(0,0).
REQ-035 RESET SHALL take priority over every other input in any state.
REQ-036 A RESET during HIT SHALL drop REACHED_TARGET to 0 on the next edge, so a truncated 1-cycle pulse is permitted.

Verification
REQ-037 Release reset -> TARGET=(80,60), TARGET_VALID=1, REACHED_TARGET=0; after 20 idle cycles the target is unchanged.
REQ-038 In ARMED with GAME_ACTIVE=1, drive HEAD=(80,60) with HEAD_VALID for 1 cycle -> REACHED_TARGET high exactly 2 cycles starting the next cycle, then TARGET_VALID returns to 1 with a new target where X<=159, Y<=119 and the target is not (80,60).
REQ-039 Drive HEAD=(80,60) with HEAD_VALID=1 and GAME_ACTIVE=0, then a separate cycle with HEAD=(80,60), HEAD_VALID=0 and GAME_ACTIVE=1 -> no REACHED_TARGET in either case; target unchanged.
REQ-040 Run 200 hits back-to-back, driving the head onto each new target -> exactly 400 REACHED_TARGET-high cycles, every target in range, never equal to the prior head position.
REQ-041 Assert RESET for 1 cycle in the second HIT cycle -> REACHED_TARGET=0 on the next edge; TARGET=(80,60), TARGET_VALID=1.
REQ-042 Hold HEAD_VALID=1 on the matching position for 10 cycles -> a single 2-cycle REACHED_TARGET pulse; no retrigger until a new target is armed and matched.
